if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//   Instruction-fetch stage. Owns the PC, requests 16-bit instructions from the I-cache, and loads
//   the IF/ID pipeline register whose ifid_instr[15:12] drives CPU control decode in ID.
//   Handles variable-latency cache responses, hazard stalls, ID-resolved branch redirects (B/BR),
//   and halting of fetch on HLT (opcode 4'hF).
// PARAMETERS
//   PC_W       16       PC / address width (byte addresses, instructions 2 bytes)
//   RESET_PC   16'h0000 PC value after reset
//   NOP_INSTR  16'h0000 instruction loaded into IF/ID on bubble/flush
// PORTS
//   clk             in   1     clock, rising edge
//   rst_n           in   1     asynchronous reset, active low
//   imem_req        out  1     fetch request to I-cache
//   imem_addr       out  PC_W  fetch address; stable while imem_req=1 and imem_valid=0
//   imem_rdata      in   16    instruction data, qualified by imem_valid
//   imem_valid      in   1     response for imem_addr this cycle (0 = miss in progress)
//   stall_if        in   1     hazard unit: hold PC and IF/ID
//   branch_taken    in   1     ID resolved taken B/BR: redirect + flush
//   branch_target   in   PC_W  redirect address
//   ifid_instr      out  16    IF/ID instruction
//   ifid_pc_plus2   out  PC_W  IF/ID PC+2 (for PCS and branch offset)
//   ifid_valid      out  1     IF/ID holds a real instruction
//   halt_fetched    out  1     fetch halted on HLT
//   stall_cycles    out  16    fetch stall counter (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_PC, state=RUN, ifid_instr=NOP_INSTR, ifid_pc_plus2=0,
//     ifid_valid=0, halt_fetched=0, stall_cycles=0, drain_addr=0. Outputs are registered except
//     imem_req/imem_addr.
//   States: RUN, DRAIN, HALTED.
//   RUN: imem_req=1, imem_addr=pc. Accept = imem_valid & ~stall_if & ~branch_taken.
//     Accept: IF/ID <= {imem_rdata, pc+2, 1}; pc <= pc+2 (mod 2^PC_W, FFFE wraps to 0000).
//       If imem_rdata[15:12]==4'hF: pc holds, state->HALTED.
//     imem_valid & stall_if: data dropped, pc and IF/ID hold; same address re-requested next cycle.
//     ~imem_valid & ~stall_if: IF/ID <= bubble (NOP_INSTR, valid 0); pc holds.
//     ~imem_valid & stall_if: everything holds.
//   branch_taken (any state, overrides stall_if): pc <= branch_target; IF/ID <= bubble;
//     halt_fetched <= 0. If in RUN with imem_valid=0 (miss outstanding): drain_addr <= pc,
//     state->DRAIN; else state->RUN.
//   DRAIN: imem_req=1, imem_addr=drain_addr (cache protocol forbids address change mid-miss).
//     On imem_valid: data discarded, state->RUN (new pc fetched next cycle). IF/ID inserts bubble
//     when ~stall_if. A further branch_taken updates pc only; stays in DRAIN.
//   HALTED: imem_req=0, halt_fetched=1, pc holds. IF/ID <= bubble when ~stall_if (HLT drains
//     into ID once); holds when stall_if. Exit only via branch_taken (older branch) or reset.
//   Latency: 1 cycle from imem_valid to ifid_valid on a cache hit; 1 instruction/cycle max.
// CONFIGURATION
//   IF_STALL_CNT_EN defined: stall_cycles increments (saturating at 16'hFFFF) each cycle
//     imem_req=1 & imem_valid=0, plus each DRAIN cycle; reset to 0.
//   Not defined: stall_cycles tied to 16'h0000; no counter flops.
// TESTING
//   Hits, rdata 16'h1234,16'h2345,16'h3456 from pc 0 -> ifid_pc_plus2 2,4,6, ifid_valid=1 each cycle.
//   Miss 3 cycles at pc 0x0010 -> 3 bubbles, imem_addr fixed 0x0010, then instr with pc_plus2 0x0012.
//   stall_if=1 for 2 cycles with hits -> IF/ID and pc frozen, no instruction lost or duplicated.
//   branch_taken, target 0x0040, during miss at 0x0020 -> DRAIN keeps addr 0x0020, response
//     dropped, next request 0x0040, no instruction from 0x0020 reaches IF/ID.
//   Fetch 16'hF000 at 0x0008 -> halt_fetched=1, imem_req=0, pc=0x0008; then branch_taken to
//     0x0100 -> halt_fetched=0, fetch resumes at 0x0100.
//   rst_n low mid-miss -> immediate reset values; first request at RESET_PC after release.

Source files
------------

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: PC, I-cache request, IF/ID register
//
// Purpose: owns the PC and fetches 16-bit instructions from the I-cache. It also
//   loads the IF/ID register, handles variable-latency cache responses, hazard
//   stalls, branch redirects resolved in ID, and halting of fetch on HLT
//   (opcode 4'hF).
// Optional feature: IF_STALL_CNT_EN adds a saturating fetch-stall counter.
//   When it is undefined, stall_cycles reads as zero.
// Ports:
//   clk, rst_n                 clock (rising edge) and async active-low reset
//   imem_req, imem_addr        fetch request/address to the I-cache
//   imem_rdata, imem_valid     I-cache response (valid=0 while a miss is in progress)
//   stall_if                   hazard hold of PC and IF/ID
//   branch_taken, branch_target  ID-resolved redirect (flushes IF/ID)
//   ifid_instr, ifid_pc_plus2, ifid_valid  IF/ID pipeline register
//   halt_fetched               fetch stopped on HLT
//   stall_cycles               fetch stall counter
module if_fetch_stage #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [15:0]     NOP_INSTR = 16'h0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_valid,
  input  logic            stall_if,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [15:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc_plus2,
  output logic            ifid_valid,
  output logic            halt_fetched,
  output logic [15:0]     stall_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] drain_addr, drain_n;
  logic [15:0]     instr_n;
  logic [PC_W-1:0] pc2_n;
  logic            valid_n;
  logic            halt_n;
  logic [PC_W-1:0] pc_plus2;

  assign pc_plus2  = pc + PC_W'(2);
  assign imem_req  = (state != HALTED);
  // While draining, the cache must keep seeing the address of the outstanding miss.
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    drain_n = drain_addr;
    instr_n = ifid_instr;
    pc2_n   = ifid_pc_plus2;
    valid_n = ifid_valid;
    halt_n  = halt_fetched;
    if (branch_taken) begin
      // Redirect wins over stall_if; whatever was fetched this cycle is wrong-path.
      pc_n    = branch_target;
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
      halt_n  = 1'b0;
      unique case (state)
        RUN: begin
          if (!imem_valid) begin
            drain_n = pc;
            state_n = DRAIN;
          end else begin
            state_n = RUN;
          end
        end
        DRAIN:   state_n = imem_valid ? RUN : DRAIN;
        default: state_n = RUN;
      endcase
    end else begin
      unique case (state)
        RUN: begin
          if (imem_valid && !stall_if) begin
            instr_n = imem_rdata;
            pc2_n   = pc_plus2;
            valid_n = 1'b1;
            if (imem_rdata[15:12] == 4'hF) begin
              state_n = HALTED;
              halt_n  = 1'b1;
            end else begin
              pc_n = pc_plus2;
            end
          end else if (!imem_valid && !stall_if) begin
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
          end
        end
        DRAIN: begin
          if (imem_valid) state_n = RUN;
          if (!stall_if) begin
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
          end
        end
        default: begin
          halt_n = 1'b1;
          if (!stall_if) begin
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RUN;
      pc            <= RESET_PC;
      drain_addr    <= '0;
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus2 <= '0;
      ifid_valid    <= 1'b0;
      halt_fetched  <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      drain_addr    <= drain_n;
      ifid_instr    <= instr_n;
      ifid_pc_plus2 <= pc2_n;
      ifid_valid    <= valid_n;
      halt_fetched  <= halt_n;
    end
  end

`ifdef IF_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stall_inc;

  // A DRAIN cycle that is also waiting on the cache counts once.
  assign stall_inc = (state == DRAIN) || (imem_req && !imem_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
    end else if (stall_inc && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        stall_if;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halt_fetched;
  logic [15:0] stall_cycles;

  int vectors = 0;
  int miscompares = 0;

  if_fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_valid    (imem_valid),
    .stall_if      (stall_if),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halt_fetched  (halt_fetched),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check the request side before the edge,
  // then advance to just after the edge.
  task automatic cyc(input string tag, input logic v, input logic [15:0] rd,
                     input logic st, input logic br, input logic [15:0] tgt,
                     input logic exp_req, input logic [15:0] exp_addr);
    imem_valid    = v;
    imem_rdata    = rd;
    stall_if      = st;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    chk({tag, ".req"}, {15'd0, imem_req}, {15'd0, exp_req});
    if (exp_req) chk({tag, ".addr"}, imem_addr, exp_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [15:0] ins, input logic [15:0] pc2,
                      input logic vld);
    chk({tag, ".valid"}, {15'd0, ifid_valid}, {15'd0, vld});
    if (vld) begin
      chk({tag, ".instr"}, ifid_instr, ins);
      chk({tag, ".pc2"}, ifid_pc_plus2, pc2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    imem_valid = 1'b0; imem_rdata = 16'h0; stall_if = 1'b0;
    branch_taken = 1'b0; branch_target = 16'h0;
    @(posedge clk); #1;
    chk("rst.instr", ifid_instr, 16'h0000);
    chk("rst.pc2", ifid_pc_plus2, 16'h0000);
    chk("rst.valid", {15'd0, ifid_valid}, 16'h0);
    chk("rst.halt", {15'd0, halt_fetched}, 16'h0);
    chk("rst.addr", imem_addr, 16'h0000);
    chk("rst.stallcnt", stall_cycles, 16'h0000);
    rst_n = 1'b1;

    // back-to-back hits
    cyc("hit0", 1, 16'h1234, 0, 0, 0, 1, 16'h0000); ifid("hit0", 16'h1234, 16'h0002, 1);
    cyc("hit1", 1, 16'h2345, 0, 0, 0, 1, 16'h0002); ifid("hit1", 16'h2345, 16'h0004, 1);
    cyc("hit2", 1, 16'h3456, 0, 0, 0, 1, 16'h0004); ifid("hit2", 16'h3456, 16'h0006, 1);

    // two stalled hits: data dropped, same address re-requested, nothing lost
    cyc("stl0", 1, 16'hAAAA, 1, 0, 0, 1, 16'h0006); ifid("stl0", 16'h3456, 16'h0006, 1);
    cyc("stl1", 1, 16'hBBBB, 1, 0, 0, 1, 16'h0006); ifid("stl1", 16'h3456, 16'h0006, 1);
    cyc("stl2", 1, 16'h4567, 0, 0, 0, 1, 16'h0006); ifid("stl2", 16'h4567, 16'h0008, 1);

    // HLT at 0x0008, then redirect out of HALTED
    cyc("hlt0", 1, 16'hF000, 0, 0, 0, 1, 16'h0008); ifid("hlt0", 16'hF000, 16'h000A, 1);
    chk("hlt0.halt", {15'd0, halt_fetched}, 16'h1);
    cyc("hlt1", 0, 16'h0000, 0, 0, 0, 0, 16'h0008); ifid("hlt1", 16'h0, 16'h0, 0);
    chk("hlt1.halt", {15'd0, halt_fetched}, 16'h1);
    chk("hlt1.pc", imem_addr, 16'h0008);
    cyc("hlt2", 0, 16'h0000, 0, 0, 0, 0, 16'h0008);
    cyc("hbr", 0, 16'h0000, 0, 1, 16'h0100, 0, 16'h0008); ifid("hbr", 16'h0, 16'h0, 0);
    chk("hbr.halt", {15'd0, halt_fetched}, 16'h0);
    cyc("res", 1, 16'h5678, 0, 0, 0, 1, 16'h0100); ifid("res", 16'h5678, 16'h0102, 1);

    // redirect on a hit to 0x0010, then a 3-cycle miss there
    cyc("br10", 1, 16'hCCCC, 0, 1, 16'h0010, 1, 16'h0102); ifid("br10", 16'h0, 16'h0, 0);
    cyc("mis0", 0, 16'h0000, 0, 0, 0, 1, 16'h0010); ifid("mis0", 16'h0, 16'h0, 0);
    cyc("mis1", 0, 16'h0000, 0, 0, 0, 1, 16'h0010); ifid("mis1", 16'h0, 16'h0, 0);
    cyc("mis2", 0, 16'h0000, 0, 0, 0, 1, 16'h0010); ifid("mis2", 16'h0, 16'h0, 0);
    cyc("mis3", 1, 16'h6789, 0, 0, 0, 1, 16'h0010); ifid("mis3", 16'h6789, 16'h0012, 1);

    // branch to 0x0040 during a miss at 0x0020: drain the old request first
    cyc("br20", 1, 16'hDDDD, 0, 1, 16'h0020, 1, 16'h0012); ifid("br20", 16'h0, 16'h0, 0);
    cyc("dm0", 0, 16'h0000, 0, 0, 0, 1, 16'h0020);
    cyc("dbr", 0, 16'h0000, 0, 1, 16'h0040, 1, 16'h0020); ifid("dbr", 16'h0, 16'h0, 0);
    cyc("dr0", 0, 16'h0000, 0, 0, 0, 1, 16'h0020); ifid("dr0", 16'h0, 16'h0, 0);
    cyc("dr1", 1, 16'hBAD1, 0, 0, 0, 1, 16'h0020); ifid("dr1", 16'h0, 16'h0, 0);
    cyc("dr2", 1, 16'h789A, 0, 0, 0, 1, 16'h0040); ifid("dr2", 16'h789A, 16'h0042, 1);

    // PC wrap at 0xFFFE
    cyc("brw", 1, 16'hEEEE, 0, 1, 16'hFFFE, 1, 16'h0042);
    cyc("wr0", 1, 16'h1111, 0, 0, 0, 1, 16'hFFFE); ifid("wr0", 16'h1111, 16'h0000, 1);
    cyc("wr1", 1, 16'h2222, 0, 0, 0, 1, 16'h0000); ifid("wr1", 16'h2222, 16'h0002, 1);

    // async reset in the middle of a miss
    imem_valid = 1'b0; stall_if = 1'b0; branch_taken = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {15'd0, ifid_valid}, 16'h0);
    chk("arst.instr", ifid_instr, 16'h0000);
    chk("arst.addr", imem_addr, 16'h0000);
    chk("arst.halt", {15'd0, halt_fetched}, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("post", 1, 16'h3333, 0, 0, 0, 1, 16'h0000); ifid("post", 16'h3333, 16'h0002, 1);
`ifndef IF_STALL_CNT_EN
    chk("stallcnt.tied", stall_cycles, 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
